// File: rtl/my_alu_pkg.sv
// Shared definitions for the ALU datapath blocks: state encoding, output width
// and default operand width for the sequential divider.
package my_alu_pkg;

    localparam int OUT_W      = 8;
    localparam int DEF_LENGTH = 5;
    localparam int CNT_W      = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/my_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not borrow.
module my_div_step #(
    parameter int LENGTH = 5
) (
    input  logic [LENGTH:0]   rem,
    input  logic              bit_in,
    input  logic [LENGTH-1:0] divisor,
    output logic [LENGTH:0]   rem_next,
    output logic              q_bit
);

    logic [LENGTH+1:0] shifted;
    logic [LENGTH+1:0] diff;

    // One spare bit above the shifted remainder makes the borrow visible.
    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {2'b00, divisor};
    assign q_bit    = ~diff[LENGTH+1];
    assign rem_next = q_bit ? diff[LENGTH:0] : shifted[LENGTH:0];

endmodule

// File: rtl/my_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/ready/done handshake and zero-extended 8-bit results.
module my_seq_divider
    import my_alu_pkg::*;
#(
    parameter int LENGTH = DEF_LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LENGTH-1:0] A,
    input  logic [LENGTH-1:0] B,
    output logic              ready,
    output logic              done,
    output logic [OUT_W-1:0]  Quotient,
    output logic [OUT_W-1:0]  Remainder,
    output logic              f_div0,
    output logic              f_zero
);

    if (LENGTH < 2 || LENGTH > 8) begin : g_bad_length
        $error("my_seq_divider: LENGTH must be in 2..8");
    end

    state_t            state, state_next;
    logic [LENGTH-1:0] aq_reg;
    logic [LENGTH-1:0] b_reg;
    logic [LENGTH:0]   r_reg;
    logic [LENGTH:0]   r_next;
    logic              q_bit;
    logic [CNT_W-1:0]  cnt;
    logic              last_step;

    // Dividend bits leave aq_reg at the top while quotient bits enter at the bottom.
    my_div_step #(.LENGTH(LENGTH)) u_step (
        .rem      (r_reg),
        .bit_in   (aq_reg[LENGTH-1]),
        .divisor  (b_reg),
        .rem_next (r_next),
        .q_bit    (q_bit)
    );

    assign last_step = (cnt == CNT_W'(LENGTH - 1));
    assign f_zero    = (Quotient == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = (B == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aq_reg    <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            f_div0    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        aq_reg <= A;
                        b_reg  <= B;
                        r_reg  <= '0;
                        cnt    <= '0;
                        if (B == '0) begin
                            Quotient  <= OUT_W'({LENGTH{1'b1}});
                            Remainder <= OUT_W'(A);
                            f_div0    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_reg  <= r_next;
                    aq_reg <= {aq_reg[LENGTH-2:0], q_bit};
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        Quotient  <= OUT_W'({aq_reg[LENGTH-2:0], q_bit});
                        Remainder <= OUT_W'(r_next);
                        f_div0    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_my_seq_divider.sv
// Directed bench for my_seq_divider (LENGTH=5): handshake timing, results,
// divide-by-zero, ignored start and mid-operation reset.
module tb_my_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] A;
    logic [4:0] B;
    logic       ready;
    logic       done;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       f_div0;
    logic       f_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    my_seq_divider #(.LENGTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .ready     (ready),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .f_div0    (f_div0),
        .f_zero    (f_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, results and the return to idle.
    // Latency counts clock edges after the start edge until done is seen.
    task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic ediv0);
        int lat;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 5'd0; B = 5'd0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".quotient"}, Quotient, eq);
        check({tag, ".remainder"}, Remainder, er);
        check({tag, ".f_div0"}, f_div0, ediv0);
        check({tag, ".f_zero"}, f_zero, (eq == 8'h00));
        if (b != 5'd0) begin
            check({tag, ".identity"}, 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".ready_back"}, ready, 1'b1);
        check({tag, ".quotient_hold"}, Quotient, eq);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int t_done;
        logic [7:0] q_seen;
        logic [7:0] r_seen;

        rst_n = 1'b0; start = 1'b0; A = 5'd0; B = 5'd0;
        repeat (2) @(negedge clk);
        A = 5'd5; B = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.ready", ready, 1'b1);
        check("reset.done", done, 1'b0);
        check("reset.quotient", Quotient, 8'h00);
        check("reset.remainder", Remainder, 8'h00);
        check("reset.f_zero", f_zero, 1'b1);
        check("reset.f_div0", f_div0, 1'b0);

        @(negedge clk);
        A = 5'd23; B = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy.ready", ready, 1'b0);
        check("busy.done", done, 1'b0);
        repeat (4) @(negedge clk);
        check("busy.done_late", done, 1'b0);
        @(negedge clk);
        check("d23_4.done", done, 1'b1);
        check("d23_4.quotient", Quotient, 8'h05);
        check("d23_4.remainder", Remainder, 8'h03);
        check("d23_4.ready_in_done", ready, 1'b0);
        @(negedge clk);
        check("d23_4.ready_back", ready, 1'b1);
        check("d23_4.done_clear", done, 1'b0);

        run_op("d0_7",  5'd0,  5'd7, 5, 8'h00, 8'h00, 1'b0);
        run_op("d31_1", 5'd31, 5'd1, 5, 8'h1F, 8'h00, 1'b0);
        run_op("d9_0",  5'd9,  5'd0, 0, 8'h1F, 8'h09, 1'b1);
        run_op("d6_3",  5'd6,  5'd3, 5, 8'h02, 8'h00, 1'b0);
        run_op("d17_5", 5'd17, 5'd5, 5, 8'h03, 8'h02, 1'b0);

        // start asserted mid-operation with other operands must be ignored
        @(negedge clk);
        A = 5'd23; B = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 5'd1; B = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; t_done = -1; q_seen = 8'h00; r_seen = 8'h00;
        for (int i = 3; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                t_done = i;
                q_seen = Quotient;
                r_seen = Remainder;
            end
        end
        check("ignore.pulses", pulses, 1);
        check("ignore.latency", t_done, 5);
        check("ignore.quotient", q_seen, 8'h05);
        check("ignore.remainder", r_seen, 8'h03);

        // reset during RUN aborts the operation
        @(negedge clk);
        A = 5'd30; B = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.ready", ready, 1'b1);
        check("abort.done", done, 1'b0);
        check("abort.quotient", Quotient, 8'h00);
        check("abort.remainder", Remainder, 8'h00);
        check("abort.f_zero", f_zero, 1'b1);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort.no_done", pulses, 0);
        check("abort.idle", ready, 1'b1);

        run_op("d30_7", 5'd30, 5'd7, 5, 8'h04, 8'h02, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
